adder_response_checker: RTL and testbench
=========================================

// Module: adder_response_checker
// PURPOSE
//  Receiving end of the adder stimulus path: takes each operand set sent to an adder DUT
//  (16..64-bit slices), delays it by the DUT latency, and compares the DUT result against
//  a golden A+B+Cin. Counts passes and failures and captures the first mismatch.
//  Sits beside the adder under test in on-board and simulation verification builds.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits (1..64)
//  LAT    0   DUT latency in clk cycles, from stimulus valid to dut_sum valid (0..8)
//  CNT_W  16  width of the pass/fail counters
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  clr        in   1        synchronous clear: flush pipeline, counters, capture
//  stim_valid in   1        operand set on stim_* is being applied to the DUT this cycle
//  stim_a     in   WIDTH    operand A
//  stim_b     in   WIDTH    operand B
//  stim_cin   in   1        carry-in
//  dut_sum    in   WIDTH    DUT sum output
//  dut_cout   in   1        DUT carry-out (used only with CHK_CARRY_OUT_EN)
//  chk_valid  out  1        one-cycle pulse: a compare completed last cycle
//  chk_pass   out  1        result of that compare (valid with chk_valid)
//  pass_cnt   out  CNT_W    number of passing compares
//  fail_cnt   out  CNT_W    number of failing compares
//  err_flag   out  1        sticky: at least one mismatch since reset/clr
//  err_a/err_b out WIDTH    operands of the first mismatch
//  err_cin    out  1        carry-in of the first mismatch
//  err_exp    out  WIDTH+1  expected {cout,sum} of the first mismatch
//  err_got    out  WIDTH+1  DUT {cout,sum} of the first mismatch
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0; delay pipeline valids 0; state IDLE.
//  - Delay line: LAT register stages of {valid,a,b,cin}. LAT=0: stage output is stim_* directly.
//  - Compare: in the cycle the delayed valid is 1, exp = a+b+cin computed at WIDTH+1 bits
//    (no truncation before compare). Mismatch when exp[WIDTH-1:0] != dut_sum.
//  - Timing: stimulus in cycle t -> dut_sum sampled at end of cycle t+LAT -> chk_valid,
//    chk_pass, counters, capture visible in cycle t+LAT+1. One compare per cycle max,
//    back-to-back stimulus fully supported.
//  - Counters saturate at 2^CNT_W-1; no wrap.
//  - FSM: IDLE (no compare yet) -> RUN on first pass; IDLE/RUN -> FAIL on first mismatch,
//    loading err_*; err_flag=1 in FAIL. FAIL is sticky: later mismatches only increment
//    fail_cnt, err_* never overwritten. Any state -> IDLE on clr.
//  - clr: next cycle counters 0, err_* 0, err_flag 0, pipeline valids 0 (in-flight dropped).
//    clr coincident with a compare: clr wins, that compare is not counted, chk_valid=0.
//  - stim_valid=0 cycles: pipeline bubble; no compare; dut_sum ignored.
//  - Reset mid-run: in-flight operand sets discarded, nothing counted.
// CONFIGURATION
//  CHK_CARRY_OUT_EN defined: mismatch also when exp[WIDTH] != dut_cout; err_got[WIDTH]=dut_cout.
//  Not defined: dut_cout ignored; only the low WIDTH bits are compared; err_exp[WIDTH] still
//  holds the true carry, err_got[WIDTH] = 0.
// TESTING
//  1. WIDTH=16,LAT=0: 100 incrementing pairs a=b=i, correct DUT -> pass_cnt=100, fail_cnt=0, err_flag=0.
//  2. LAT=2: a=16'h1234,b=16'h0001, dut_sum=16'h1235 two cycles later -> chk_valid at t+3, chk_pass=1.
//  3. Wrap: a=16'hFFFF,b=16'h0001,cin=0, dut_sum=0, dut_cout=0 -> pass without CHK_CARRY_OUT_EN;
//     with it, fail, err_exp=17'h10000, err_got=17'h00000.
//  4. Two mismatches (cycles 5,9): err_* hold cycle-5 values, fail_cnt=2, FSM stays FAIL.
//  5. CNT_W=4: 20 passing compares -> pass_cnt=4'hF (saturated); then clr -> all counters 0, IDLE.
//  6. rst_n low with 2 sets in flight (LAT=2), then release -> no chk_valid, counters stay 0.

Source files
------------

// File: rtl/adder_response_checker.sv
// adder_response_checker
//   Receiving end of an adder stimulus path. Each operand set applied to the
//   adder under test is delayed by the adder latency LAT. The delayed set is
//   then compared against the golden A+B+Cin, computed at WIDTH+1 bits. The
//   block counts passing and failing compares and captures the operands and
//   results of the first mismatch.
//
//   Optional feature, macro CHK_CARRY_OUT_EN:
//     defined   - the adder carry-out is compared too, and err_got[WIDTH]
//                 holds dut_cout.
//     undefined - dut_cout is ignored and only the low WIDTH bits are
//                 compared. err_exp[WIDTH] still holds the true carry, and
//                 err_got[WIDTH] is 0.
//
// Parameters
//   WIDTH  operand/sum width (1..64)
//   LAT    adder latency in clk cycles (0..8)
//   CNT_W  pass/fail counter width
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous clear of pipeline, counters, capture and FSM
//   stim_valid/a/b/cin operand set applied to the adder this cycle
//   dut_sum, dut_cout  adder result, valid LAT cycles after the stimulus
//   chk_valid/chk_pass one-cycle compare result, one cycle after dut_sum is sampled
//   pass_cnt/fail_cnt  saturating compare counters
//   err_flag           sticky mismatch indicator (FSM in FAIL)
//   err_a/b/cin        operands of the first mismatch
//   err_exp/err_got    expected / observed {cout,sum} of the first mismatch
`timescale 1ns/1ps
module adder_response_checker #(
  parameter int WIDTH = 16,
  parameter int LAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic             stim_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic             err_cin,
  output logic [WIDTH:0]   err_exp,
  output logic [WIDTH:0]   err_got
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic             vld_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             cin_p0;

  // ---- stage: stimulus delay line, aligns operands with dut_sum ----
  generate
    if (LAT == 0) begin : g_nodly
      assign vld_p0 = stim_valid;
      assign a_p0   = stim_a;
      assign b_p0   = stim_b;
      assign cin_p0 = stim_cin;
    end else begin : g_dly
      logic [LAT-1:0]   vld_q;
      logic [WIDTH-1:0] a_q   [LAT];
      logic [WIDTH-1:0] b_q   [LAT];
      logic [LAT-1:0]   cin_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else if (clr) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= stim_valid;
          for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      // Operand payload carries no reset; only the valid bits qualify it.
      always_ff @(posedge clk) begin
        a_q[0]   <= stim_a;
        b_q[0]   <= stim_b;
        cin_q[0] <= stim_cin;
        for (int i = 1; i < LAT; i++) begin
          a_q[i]   <= a_q[i-1];
          b_q[i]   <= b_q[i-1];
          cin_q[i] <= cin_q[i-1];
        end
      end

      assign vld_p0 = vld_q[LAT-1];
      assign a_p0   = a_q[LAT-1];
      assign b_p0   = b_q[LAT-1];
      assign cin_p0 = cin_q[LAT-1];
    end
  endgenerate

  // ---- stage: golden compare against the adder output ----
  logic [WIDTH:0] exp_p0;
  logic [WIDTH:0] got_p0;
  logic           mismatch_p0;
  logic           cmp_p0;

  assign exp_p0 = {1'b0, a_p0} + {1'b0, b_p0} + {{WIDTH{1'b0}}, cin_p0};

`ifdef CHK_CARRY_OUT_EN
  assign got_p0      = {dut_cout, dut_sum};
  assign mismatch_p0 = (exp_p0 != got_p0);
`else
  logic unused_dut_cout;
  assign unused_dut_cout = dut_cout;
  assign got_p0      = {1'b0, dut_sum};
  assign mismatch_p0 = (exp_p0[WIDTH-1:0] != dut_sum);
`endif

  // A clear in the compare cycle discards that compare entirely.
  assign cmp_p0 = vld_p0 & ~clr;

  state_t state;
  state_t state_nxt;
  logic   capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else if (cmp_p0) begin
      if (mismatch_p0)           state_nxt = ST_FAIL;
      else if (state == ST_IDLE) state_nxt = ST_RUN;
    end
  end

  always_comb begin
    err_flag = (state == ST_FAIL);
    // Only the first mismatch is captured; FAIL is sticky until clr/reset.
    capture  = cmp_p0 & mismatch_p0 & (state != ST_FAIL);
  end

  // ---- stage: registered results, counters and first-mismatch capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_a     <= '0;
      err_b     <= '0;
      err_cin   <= 1'b0;
      err_exp   <= '0;
      err_got   <= '0;
    end else if (clr) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_a     <= '0;
      err_b     <= '0;
      err_cin   <= 1'b0;
      err_exp   <= '0;
      err_got   <= '0;
    end else begin
      chk_valid <= cmp_p0;
      chk_pass  <= cmp_p0 & ~mismatch_p0;
      if (cmp_p0 && !mismatch_p0) pass_cnt <= sat_inc(pass_cnt);
      if (cmp_p0 &&  mismatch_p0) fail_cnt <= sat_inc(fail_cnt);
      if (capture) begin
        err_a   <= a_p0;
        err_b   <= b_p0;
        err_cin <= cin_p0;
        err_exp <= exp_p0;
        err_got <= got_p0;
      end
    end
  end

endmodule

// File: tb/tb_adder_response_checker.sv
// Testbench for adder_response_checker: WIDTH=16, LAT=2, CNT_W=8.
// A behavioural two-stage adder drives dut_sum/dut_cout. A per-vector XOR
// mask corrupts chosen results. The expected chk_pass of each vector goes
// into a queue, and a forked monitor pops that queue on every chk_valid.
`timescale 1ns/1ps
module tb_adder_response_checker;
  localparam int W = 16;
  localparam int L = 2;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         stim_valid = 1'b0;
  logic [W-1:0] stim_a = '0;
  logic [W-1:0] stim_b = '0;
  logic         stim_cin = 1'b0;
  logic [W-1:0] dut_sum;
  logic         dut_cout;
  logic         chk_valid, chk_pass, err_flag, err_cin;
  logic [C-1:0] pass_cnt, fail_cnt;
  logic [W-1:0] err_a, err_b;
  logic [W:0]   err_exp, err_got;

  logic [W:0]   drv_mask = '0;
  logic [W:0]   m_s1, m_s2;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  // Adder under test model: latency 2, with optional result corruption
  always @(posedge clk) begin
    m_s1 <= ({1'b0, stim_a} + {1'b0, stim_b} + {{W{1'b0}}, stim_cin}) ^ drv_mask;
    m_s2 <= m_s1;
  end
  assign dut_sum  = m_s2[W-1:0];
  assign dut_cout = m_s2[W];

  adder_response_checker #(.WIDTH(W), .LAT(L), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b), .stim_cin(stim_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .chk_valid(chk_valid), .chk_pass(chk_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag),
    .err_a(err_a), .err_b(err_b), .err_cin(err_cin),
    .err_exp(err_exp), .err_got(err_got)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic [W:0] mask);
    bit p;
    @(negedge clk);
    stim_valid = 1'b1;
    stim_a     = a;
    stim_b     = b;
    stim_cin   = cin;
    drv_mask   = mask;
    p = (mask[W-1:0] == '0);
`ifdef CHK_CARRY_OUT_EN
    p = p && !mask[W];
`endif
    exp_q.push_back(p);
  endtask

  task automatic stop();
    @(negedge clk);
    stim_valid = 1'b0;
    drv_mask   = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d compares outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && chk_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_chk_valid: got chk_valid=1, expected 0");
          end else begin
            bit e;
            e = exp_q.pop_front();
            check("monitor_chk_pass", 64'(chk_pass), 64'(e));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_chk_valid", 64'(chk_valid), 64'd0);
    check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
    check("rst_err_flag", 64'(err_flag), 64'd0);
    check("rst_err_got", 64'(err_got), 64'd0);
    rst_n = 1'b1;

    // 100 incrementing pairs, all correct
    for (int i = 0; i < 100; i++) send(W'(i), W'(i), 1'b0, '0);
    stop();
    drain();
    check("t1_pass_cnt", 64'(pass_cnt), 64'd100);
    check("t1_fail_cnt", 64'(fail_cnt), 64'd0);
    check("t1_err_flag", 64'(err_flag), 64'd0);

    // Latency: compare result visible three cycles after the stimulus
    do_clr();
    send(16'h1234, 16'h0001, 1'b0, '0);
    stop();
    check("t2_valid_t1", 64'(chk_valid), 64'd0);
    @(negedge clk);
    check("t2_valid_t2", 64'(chk_valid), 64'd0);
    @(negedge clk);
    check("t2_valid_t3", 64'(chk_valid), 64'd1);
    check("t2_pass_t3", 64'(chk_pass), 64'd1);
    drain();
    check("t2_pass_cnt", 64'(pass_cnt), 64'd1);

    // Wrap with wrong carry-out, then a full-carry correct case
    do_clr();
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    send(16'hFFFF, 16'hFFFF, 1'b1, '0);
    stop();
    drain();
`ifdef CHK_CARRY_OUT_EN
    check("t3_pass_cnt", 64'(pass_cnt), 64'd1);
    check("t3_fail_cnt", 64'(fail_cnt), 64'd1);
    check("t3_err_flag", 64'(err_flag), 64'd1);
    check("t3_err_exp", 64'(err_exp), 64'h10000);
    check("t3_err_got", 64'(err_got), 64'h00000);
`else
    check("t3_pass_cnt", 64'(pass_cnt), 64'd2);
    check("t3_fail_cnt", 64'(fail_cnt), 64'd0);
    check("t3_err_flag", 64'(err_flag), 64'd0);
`endif

    // Two mismatches (vectors 5 and 9); only the first is captured
    do_clr();
    for (int i = 0; i < 12; i++)
      send(16'h1000 + W'(i), 16'h0200, i[0], (i == 5 || i == 9) ? 17'h00001 : 17'h0);
    stop();
    drain();
    check("t4_fail_cnt", 64'(fail_cnt), 64'd2);
    check("t4_pass_cnt", 64'(pass_cnt), 64'd10);
    check("t4_err_flag", 64'(err_flag), 64'd1);
    check("t4_err_a", 64'(err_a), 64'h1005);
    check("t4_err_b", 64'(err_b), 64'h0200);
    check("t4_err_cin", 64'(err_cin), 64'd1);
    check("t4_err_exp", 64'(err_exp), 64'h01206);
    check("t4_err_got", 64'(err_got), 64'h01207);

    // Pass counter saturation while FAIL stays sticky, then clear
    for (int i = 0; i < 300; i++) send(W'(i), 16'h0001, 1'b0, '0);
    stop();
    drain();
    check("t5_pass_sat", 64'(pass_cnt), 64'hFF);
    check("t5_fail_cnt", 64'(fail_cnt), 64'd2);
    check("t5_err_flag", 64'(err_flag), 64'd1);
    check("t5_err_a_kept", 64'(err_a), 64'h1005);
    do_clr();
    check("t5_clr_pass", 64'(pass_cnt), 64'd0);
    check("t5_clr_fail", 64'(fail_cnt), 64'd0);
    check("t5_clr_flag", 64'(err_flag), 64'd0);
    check("t5_clr_err_a", 64'(err_a), 64'd0);
    check("t5_clr_err_exp", 64'(err_exp), 64'd0);

    // Clear coincident with a compare: the compare is dropped
    send(16'h0005, 16'h0006, 1'b0, '0);
    stop();
    @(negedge clk);
    clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clr = 1'b0;
    check("clr_cmp_valid", 64'(chk_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("clr_cmp_pass_cnt", 64'(pass_cnt), 64'd0);

    // Reset with two sets in flight
    send(16'h0001, 16'h0002, 1'b0, '0);
    send(16'h0003, 16'h0004, 1'b0, '0);
    stop();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_valid", 64'(chk_valid), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_pass_cnt", 64'(pass_cnt), 64'd0);
    check("t6_fail_cnt", 64'(fail_cnt), 64'd0);
    check("t6_err_flag", 64'(err_flag), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
